// File: rtl/mem_arbiter_rr.sv
// N-port burst arbiter: L1 cache ports share one memory/L2 burst port.
// One transaction at a time; grant locked IDLE->BUSY->DONE, memory outputs registered.
module mem_arbiter_rr #(
  parameter int NUM_PORTS     = 2,
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 128,
  parameter int PRIORITY_MODE = 0,
  localparam int GID_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          port_read,
  input  logic [NUM_PORTS-1:0]          port_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_address,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_wdata,
  output logic [NUM_PORTS-1:0]          port_resp,
  output logic [DATA_W-1:0]             port_rdata,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_resp,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy,
  output logic [GID_W-1:0]              grant_id
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [GID_W-1:0]    grant_id_q, grant_id_d;
  logic [GID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [NUM_PORTS-1:0] req;
  logic                 any_req;
  logic [GID_W-1:0]     win_lo, win_hi, win_id;
  logic                 has_hi;
  logic [ADDR_W-1:0]    win_addr;
  logic [DATA_W-1:0]    win_wdata;
  logic                 win_rd, win_wr;

  // Round-robin: lowest requester above rr_ptr, otherwise wrap to the lowest overall.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req     = port_read | port_write;
    any_req = |req;
    win_lo  = '0;
    win_hi  = '0;
    has_hi  = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_lo = GID_W'(i);
        if (i > int'(rr_ptr_q)) begin
          win_hi = GID_W'(i);
          has_hi = 1'b1;
        end
      end
    end
    if (PRIORITY_MODE == 1) win_id = win_lo;
    else                    win_id = has_hi ? win_hi : win_lo;
    win_addr  = port_address[int'(win_id)*ADDR_W +: ADDR_W];
    win_wdata = port_wdata[int'(win_id)*DATA_W +: DATA_W];
    win_rd    = port_read[win_id];
    win_wr    = port_write[win_id];
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d       = BUSY;
          grant_id_d    = win_id;
          if (PRIORITY_MODE == 0) rr_ptr_d = win_id;
          mem_address_d = win_addr;
          mem_wdata_d   = win_wdata;
          // Write wins when a port raises both strobes.
          mem_write_d   = win_wr;
          mem_read_d    = win_rd & ~win_wr;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_id_q    <= '0;
      rr_ptr_q      <= GID_W'(NUM_PORTS - 1);
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  always_comb begin
    port_resp = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_resp[i] = (state_q == BUSY) && mem_resp && (int'(grant_id_q) == i);
    end
  end

  assign port_rdata  = mem_rdata;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: 2-port round-robin, 2-port fixed priority
// and 4-port round-robin instances sharing clock and reset.
module tb_mem_arbiter_rr;

  localparam logic [127:0] A5 = {16{8'hA5}};

  logic clk = 1'b0;
  logic reset;
  logic [127:0] mem_rdata;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance a: NUM_PORTS=2, round-robin
  logic [1:0]   a_port_read, a_port_write, a_port_resp;
  logic [31:0]  a_port_address;
  logic [255:0] a_port_wdata;
  logic [127:0] a_port_rdata, a_mem_wdata;
  logic         a_mem_read, a_mem_write, a_mem_resp, a_busy;
  logic [15:0]  a_mem_address;
  logic [0:0]   a_grant_id;

  mem_arbiter_rr #(.NUM_PORTS(2), .PRIORITY_MODE(0)) dut_a (
    .clk(clk), .reset(reset),
    .port_read(a_port_read), .port_write(a_port_write),
    .port_address(a_port_address), .port_wdata(a_port_wdata),
    .port_resp(a_port_resp), .port_rdata(a_port_rdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write),
    .mem_address(a_mem_address), .mem_wdata(a_mem_wdata),
    .mem_resp(a_mem_resp), .mem_rdata(mem_rdata),
    .busy(a_busy), .grant_id(a_grant_id)
  );

  // Instance b: NUM_PORTS=2, fixed priority
  logic [1:0]   b_port_read, b_port_write, b_port_resp;
  logic [31:0]  b_port_address;
  logic [255:0] b_port_wdata;
  logic [127:0] b_port_rdata, b_mem_wdata;
  logic         b_mem_read, b_mem_write, b_mem_resp, b_busy;
  logic [15:0]  b_mem_address;
  logic [0:0]   b_grant_id;

  mem_arbiter_rr #(.NUM_PORTS(2), .PRIORITY_MODE(1)) dut_b (
    .clk(clk), .reset(reset),
    .port_read(b_port_read), .port_write(b_port_write),
    .port_address(b_port_address), .port_wdata(b_port_wdata),
    .port_resp(b_port_resp), .port_rdata(b_port_rdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_address(b_mem_address), .mem_wdata(b_mem_wdata),
    .mem_resp(b_mem_resp), .mem_rdata(mem_rdata),
    .busy(b_busy), .grant_id(b_grant_id)
  );

  // Instance c: NUM_PORTS=4, round-robin
  logic [3:0]   c_port_read, c_port_write, c_port_resp;
  logic [63:0]  c_port_address;
  logic [511:0] c_port_wdata;
  logic [127:0] c_port_rdata, c_mem_wdata;
  logic         c_mem_read, c_mem_write, c_mem_resp, c_busy;
  logic [15:0]  c_mem_address;
  logic [1:0]   c_grant_id;

  mem_arbiter_rr #(.NUM_PORTS(4), .PRIORITY_MODE(0)) dut_c (
    .clk(clk), .reset(reset),
    .port_read(c_port_read), .port_write(c_port_write),
    .port_address(c_port_address), .port_wdata(c_port_wdata),
    .port_resp(c_port_resp), .port_rdata(c_port_rdata),
    .mem_read(c_mem_read), .mem_write(c_mem_write),
    .mem_address(c_mem_address), .mem_wdata(c_mem_wdata),
    .mem_resp(c_mem_resp), .mem_rdata(mem_rdata),
    .busy(c_busy), .grant_id(c_grant_id)
  );

  task automatic test_reset();
    reset = 1'b1;
    a_port_read = '0; a_port_write = '0; a_port_address = '0; a_port_wdata = '0; a_mem_resp = 1'b0;
    b_port_read = '0; b_port_write = '0; b_port_address = '0; b_port_wdata = '0; b_mem_resp = 1'b0;
    c_port_read = '0; c_port_write = '0; c_port_address = '0; c_port_wdata = '0; c_mem_resp = 1'b0;
    mem_rdata = A5;
    #1;
    checks++;
    if ({a_mem_read, a_mem_write, a_busy, a_port_resp} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 00000", {a_mem_read, a_mem_write, a_busy, a_port_resp});
    end
    checks++;
    if ({a_grant_id, a_mem_address, a_mem_wdata} !== 145'b0) begin
      errors++; $display("FAIL reset_regs: got %h/%h/%h want 0", a_grant_id, a_mem_address, a_mem_wdata);
    end
    checks++;
    if ({c_mem_read, c_mem_write, c_busy, c_port_resp, c_grant_id} !== 9'b0) begin
      errors++; $display("FAIL reset_c: got %b want 0", {c_mem_read, c_mem_write, c_busy, c_port_resp, c_grant_id});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int exp_g[4] = '{0, 1, 0, 1};
    int g = 0;
    logic [1:0] exp_resp;
    a_port_read = 2'b11;
    for (int cyc = 0; cyc < 40 && g < 4; cyc++) begin
      @(negedge clk);
      a_mem_resp = 1'b0;
      if (a_mem_read) begin
        checks++;
        if (a_grant_id !== 1'(exp_g[g])) begin
          errors++; $display("FAIL rr_grant%0d: got %0d want %0d", g, a_grant_id, exp_g[g]);
        end
        exp_resp = 2'(1 << exp_g[g]);
        a_mem_resp = 1'b1;
        #1;
        checks++;
        if (a_port_resp !== exp_resp) begin
          errors++; $display("FAIL rr_resp%0d: got %b want %b", g, a_port_resp, exp_resp);
        end
        g++;
        if (g == 4) a_port_read = 2'b00;
      end
    end
    checks++;
    if (g != 4) begin
      errors++; $display("FAIL rr_timeout: got %0d grants want 4", g);
    end
    @(negedge clk); a_mem_resp = 1'b0; a_port_read = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    int exp_g[4] = '{0, 0, 0, 1};
    int g = 0;
    logic [1:0] exp_resp;
    b_port_read = 2'b11;
    for (int cyc = 0; cyc < 40 && g < 4; cyc++) begin
      @(negedge clk);
      b_mem_resp = 1'b0;
      if (b_mem_read) begin
        checks++;
        if (b_grant_id !== 1'(exp_g[g])) begin
          errors++; $display("FAIL fp_grant%0d: got %0d want %0d", g, b_grant_id, exp_g[g]);
        end
        exp_resp = 2'(1 << exp_g[g]);
        b_mem_resp = 1'b1;
        #1;
        checks++;
        if (b_port_resp !== exp_resp) begin
          errors++; $display("FAIL fp_resp%0d: got %b want %b", g, b_port_resp, exp_resp);
        end
        g++;
        if (g == 3) b_port_read = 2'b10;
        if (g == 4) b_port_read = 2'b00;
      end
    end
    checks++;
    if (g != 4) begin
      errors++; $display("FAIL fp_timeout: got %0d grants want 4", g);
    end
    @(negedge clk); b_mem_resp = 1'b0; b_port_read = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    @(negedge clk);
    a_mem_resp = 1'b1;
    #1;
    checks++;
    if (a_port_resp !== 2'b00) begin
      errors++; $display("FAIL idle_resp_ignored: got %b want 00", a_port_resp);
    end
    a_mem_resp = 1'b0;
    a_port_read = 2'b10;
    a_port_address = {16'h1230, 16'h0000};
    @(negedge clk);
    checks++;
    if ({a_mem_read, a_mem_write, a_busy, a_grant_id} !== 4'b1011) begin
      errors++; $display("FAIL read_strobe: got rd%b wr%b busy%b gid%b want 1 0 1 1", a_mem_read, a_mem_write, a_busy, a_grant_id);
    end
    checks++;
    if (a_mem_address !== 16'h1230) begin
      errors++; $display("FAIL read_addr: got %h want 1230", a_mem_address);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({a_mem_read, a_port_resp} !== 3'b100) begin
      errors++; $display("FAIL read_wait: got rd%b resp%b want 1 00", a_mem_read, a_port_resp);
    end
    a_mem_resp = 1'b1;
    #1;
    checks++;
    if (a_port_resp !== 2'b10) begin
      errors++; $display("FAIL read_resp: got %b want 10", a_port_resp);
    end
    checks++;
    if (a_port_rdata !== A5) begin
      errors++; $display("FAIL read_rdata: got %h want %h", a_port_rdata, A5);
    end
    @(negedge clk);
    a_mem_resp = 1'b0;
    a_port_read = 2'b00;
    checks++;
    if ({a_mem_read, a_busy} !== 2'b01) begin
      errors++; $display("FAIL read_done: got rd%b busy%b want 0 1", a_mem_read, a_busy);
    end
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0) begin
      errors++; $display("FAIL read_idle_busy: got %b want 0", a_busy);
    end
  endtask

  task automatic test_write_latch();
    a_port_write = 2'b01;
    a_port_address = {16'h0000, 16'h00F0};
    a_port_wdata = {128'h0, 128'h1};
    @(negedge clk);
    checks++;
    if ({a_mem_write, a_mem_read, a_grant_id} !== 3'b100) begin
      errors++; $display("FAIL write_strobe: got wr%b rd%b gid%b want 1 0 0", a_mem_write, a_mem_read, a_grant_id);
    end
    a_port_address = {16'h0000, 16'h0100};
    a_port_wdata = {128'h0, 128'hFF};
    a_port_write = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (a_mem_address !== 16'h00F0 || a_mem_wdata !== 128'h1 || a_mem_write !== 1'b1) begin
        errors++; $display("FAIL write_hold%0d: got addr %h wdata %h wr %b want 00f0 1 1", k, a_mem_address, a_mem_wdata, a_mem_write);
      end
    end
    a_mem_resp = 1'b1;
    #1;
    checks++;
    if (a_port_resp !== 2'b01) begin
      errors++; $display("FAIL write_resp: got %b want 01", a_port_resp);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({a_port_resp, a_mem_write} !== 3'b000) begin
      errors++; $display("FAIL done_resp_ignored: got resp%b wr%b want 00 0", a_port_resp, a_mem_write);
    end
    a_mem_resp = 1'b0;
    @(negedge clk);
  endtask

  task automatic c_txn(input logic [3:0] rd, input logic [3:0] wr, input logic [1:0] exp_gid,
                       input logic exp_rd, input logic exp_wr, input logic [15:0] exp_addr);
    bit seen = 0;
    logic [3:0] exp_resp;
    c_port_read = rd;
    c_port_write = wr;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      seen = c_mem_read | c_mem_write;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL c_timeout: got no strobe want grant %0d", exp_gid);
    end
    checks++;
    if ({c_grant_id, c_mem_read, c_mem_write} !== {exp_gid, exp_rd, exp_wr}) begin
      errors++; $display("FAIL c_grant: got gid%0d rd%b wr%b want gid%0d rd%b wr%b",
                         c_grant_id, c_mem_read, c_mem_write, exp_gid, exp_rd, exp_wr);
    end
    checks++;
    if (c_mem_address !== exp_addr) begin
      errors++; $display("FAIL c_addr: got %h want %h", c_mem_address, exp_addr);
    end
    exp_resp = 4'(1 << exp_gid);
    c_mem_resp = 1'b1;
    #1;
    checks++;
    if (c_port_resp !== exp_resp) begin
      errors++; $display("FAIL c_resp: got %b want %b", c_port_resp, exp_resp);
    end
    @(negedge clk);
    c_mem_resp = 1'b0;
    c_port_read = '0;
    c_port_write = '0;
    @(negedge clk);
  endtask

  task automatic test_conflict_wrap();
    c_port_address = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    c_txn(4'b0100, 4'b0100, 2'd2, 1'b0, 1'b1, 16'h3333);
    c_txn(4'b1010, 4'b0000, 2'd3, 1'b1, 1'b0, 16'h4444);
    c_txn(4'b0011, 4'b0000, 2'd0, 1'b1, 1'b0, 16'h1111);
    c_txn(4'b0100, 4'b0010, 2'd1, 1'b0, 1'b1, 16'h2222);
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    a_port_read = 2'b01;
    @(negedge clk);
    checks++;
    if (a_mem_read !== 1'b1) begin
      errors++; $display("FAIL rst_pre_read: got %b want 1", a_mem_read);
    end
    #2;
    reset = 1'b1;
    a_mem_resp = 1'b1;
    #1;
    checks++;
    if ({a_mem_read, a_busy, a_port_resp} !== 4'b0000) begin
      errors++; $display("FAIL rst_async: got rd%b busy%b resp%b want 0 0 00", a_mem_read, a_busy, a_port_resp);
    end
    @(negedge clk);
    reset = 1'b0;
    a_mem_resp = 1'b0;
    a_port_read = 2'b11;
    @(negedge clk);
    checks++;
    if ({a_mem_read, a_grant_id} !== 2'b10) begin
      errors++; $display("FAIL rst_first_grant: got rd%b gid%0d want 1 0", a_mem_read, a_grant_id);
    end
    a_port_read = 2'b00;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_single_read();
    test_write_latch();
    test_conflict_wrap();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- N-port burst arbiter between the split L1 caches (instruction, data, and any future prefetch or victim ports) and the single physical-memory (or L2) burst port.
- Generalises the two-port pass-through arbiter:
  - parametrised port count and widths;
  - selectable round-robin or fixed priority;
  - request latching and grant locking for the whole transaction;
  - registered memory-side outputs.
- One transaction is outstanding at a time.

Parameters:
- NUM_PORTS, 2, number of requesting ports (2..8).
- ADDR_W, 16, address width (lc3b_word).
- DATA_W, 128, burst width (lc3b_burst).
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- port_read  in  NUM_PORTS  per-port read request, held until its port_resp.
- port_write  in  NUM_PORTS  per-port write request, held until its port_resp.
- port_address  in  NUM_PORTS*ADDR_W  packed per-port address, port i at bits [i*ADDR_W +: ADDR_W].
- port_wdata  in  NUM_PORTS*DATA_W  packed per-port write burst.
- port_resp  out  NUM_PORTS  one-hot completion pulse.
- port_rdata  out  DATA_W  read burst, broadcast to all ports; qualify with port_resp.
- mem_read  out  1  registered read strobe to memory.
- mem_write  out  1  registered write strobe to memory.
- mem_address  out  ADDR_W  registered address to memory.
- mem_wdata  out  DATA_W  registered write burst to memory.
- mem_resp  in  1  memory completion, single-cycle pulse.
- mem_rdata  in  DATA_W  memory read burst, valid when mem_resp=1.
- busy  out  1  high while a transaction is granted (BUSY or DONE).
- grant_id  out  clog2(NUM_PORTS), min 1  index of the granted port; holds the last value when idle.

Behaviour:

Reset (async, takes effect immediately):
- State = IDLE.
- mem_read, mem_write, port_resp and busy = 0.
- mem_address, mem_wdata and grant_id = 0.
- rr_ptr = NUM_PORTS-1, so port 0 wins first.

States:
- IDLE:
  - Request vector req[i] = port_read[i] | port_write[i].
  - If any req is set: select a winner, latch grant_id, address and wdata, and set the op, then go to BUSY.
  - The memory strobe rises in the cycle after the request is first seen in IDLE (1-cycle arbitration latency).
- BUSY:
  - mem_* outputs are held from the latched values.
  - Port inputs are ignored: withdrawing or changing a request does not alter the transaction.
  - On mem_resp=1:
    - port_resp[grant_id]=1 combinationally in the same cycle, with port_rdata = mem_rdata.
    - mem_read and mem_write clear at the next edge.
    - Next state = DONE.
- DONE:
  - One dead cycle with no arbitration, so the requester can drop its request. This prevents a stale re-grant.
  - Next state = IDLE.
  - busy=0 from IDLE onward.

Winner selection:
- PRIORITY_MODE=0: the first requesting port scanning upward from rr_ptr+1 modulo NUM_PORTS. rr_ptr is updated to the granted index when the grant is latched.
- PRIORITY_MODE=1: the lowest-index requesting port. rr_ptr is unused.

Op rules:
- If port_read and port_write are both high on the winning port, the write takes precedence: mem_write=1 and mem_read=0. mem_read and mem_write are never both 1.
- port_rdata is driven to mem_rdata at all times.
- port_resp is only ever high for the granted port, and only during a BUSY-state mem_resp.

Boundary conditions:
- mem_resp in IDLE or DONE: ignored, no port_resp.
- NUM_PORTS=1: always grants port 0. Timing is unchanged (IDLE->BUSY->DONE).
- Reset asserted mid-BUSY: the transaction is abandoned and outputs are cleared immediately. No port_resp is produced for the abandoned request.
- Requests present but unchanged across DONE: re-arbitrated normally in the next IDLE cycle.
- Wrap-around: with rr_ptr=NUM_PORTS-1, the scan starts at 0.

Throughput: at most one transaction per (3 + memory latency) cycles.

Test Plan:
- Single read:
  - Stimulus: port 1 read to 0x1230 from IDLE; mem_resp after 4 cycles with rdata=128'hA5...A5.
  - Required: mem_read=1 and mem_address=0x1230 one cycle after the request; port_resp=2'b10 with port_rdata=A5 pattern in the mem_resp cycle; mem_read=0 the next cycle; busy low 2 cycles after mem_resp.
- Round-robin fairness:
  - Stimulus: NUM_PORTS=2, mode 0; both ports request continuously; memory responds in 1 cycle.
  - Required: grant sequence 0,1,0,1.
- Fixed priority:
  - Stimulus: same stimulus with PRIORITY_MODE=1.
  - Required: port 0 granted repeatedly; port 1 is granted only when port 0 drops its request.
- Write latching:
  - Stimulus: port 0 write to 0x00F0 with wdata=128'h1; port 0 changes address to 0x0100 mid-BUSY.
  - Required: mem_address stays 0x00F0 and mem_wdata=1 until mem_resp.
- Read+write conflict:
  - Stimulus: port 2 (NUM_PORTS=4) asserts both read and write.
  - Required: mem_write=1, mem_read=0.
- Reset mid-BUSY:
  - Stimulus: assert reset while mem_read=1.
  - Required: mem_read=0 and busy=0 immediately (asynchronously); no port_resp; after deassert, with both ports requesting, port 0 wins first.
